// File: rtl/sic_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sic_mem_arbiter_pkg
// Shared definitions for the SIC data-memory arbiter:
//   mem_arb_state_t  - arbiter FSM states (IDLE: no owner, OWN: owner valid)
//   MEM_WORD_ADDR_W  - data-memory word-address width
//   id_age()         - wrap-safe age of an issue id relative to a base id
// ---------------------------------------------------------------------------
package sic_mem_arbiter_pkg;

    localparam int MEM_WORD_ADDR_W = 30;

    // Widest issue id supported by id_age(); callers zero-extend into it.
    localparam int ID_MAX_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } mem_arb_state_t;

    // Age = (id - base) mod 2^width. Ids wrap, so a plain unsigned
    // subtraction masked to the id width orders them correctly.
    function automatic logic [ID_MAX_W-1:0] id_age(
        input logic [ID_MAX_W-1:0] id,
        input logic [ID_MAX_W-1:0] base,
        input int unsigned         width
    );
        logic [ID_MAX_W-1:0] mask;
        mask = (ID_MAX_W'(1) << width) - ID_MAX_W'(1);
        return (id - base) & mask;
    endfunction

endpackage

// File: rtl/sic_age_select.sv
// ---------------------------------------------------------------------------
// sic_age_select
// Combinational oldest-issue-id-first selector.
//   req       in  per-SIC request
//   ids       in  packed issue ids, SIC i at [i*ID_WIDTH +: ID_WIDTH]
//   base      in  oldest in-flight issue id (age zero point)
//   excl      in  mask of SICs that may not win this cycle
//   win_idx   out index of the winner (smallest age, lowest index on tie)
//   win_valid out at least one eligible requester exists
// ---------------------------------------------------------------------------
module sic_age_select
    import sic_mem_arbiter_pkg::*;
#(
    parameter int NUM_SIC  = 4,
    parameter int ID_WIDTH = 6,
    parameter int IDX_W    = 2
) (
    input  logic [NUM_SIC-1:0]          req,
    input  logic [NUM_SIC*ID_WIDTH-1:0] ids,
    input  logic [ID_WIDTH-1:0]         base,
    input  logic [NUM_SIC-1:0]          excl,
    output logic [IDX_W-1:0]            win_idx,
    output logic                        win_valid
);

    logic [ID_WIDTH-1:0] best_age;
    logic [ID_WIDTH-1:0] age;

    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        best_age  = '0;
        age       = '0;
        for (int unsigned i = 0; i < NUM_SIC; i++) begin
            age = ID_WIDTH'(id_age(ID_MAX_W'(ids[i*ID_WIDTH +: ID_WIDTH]),
                                   ID_MAX_W'(base), ID_WIDTH));
            // Strict less-than keeps the lower index on equal ages.
            if (req[i] && !excl[i] && (!win_valid || age < best_age)) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                best_age  = age;
            end
        end
    end

endmodule

// File: rtl/sic_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sic_mem_arbiter
// Grants one SIC at a time exclusive use of the single data-memory port,
// oldest issue id first, and muxes the owner's address/data/write enable
// onto the SRAM. Read data is broadcast unchanged.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               per-SIC lock request (level)
//   req_issue_id      per-SIC issue id (packed, ID_WIDTH each)
//   release_lock      owner ends its access this cycle
//   oldest_issue_id   age base for the oldest-first compare
//   sic_addr/wdata/wen per-SIC memory access fields
//   grant             one-hot grant (combinational from the owner register)
//   mem_addr/wdata/wen SRAM port, driven from the owner; zero when idle
//   mem_rdata, rdata  SRAM read data in, broadcast out
//   busy              an owner is present
//   timeout_err       sticky watchdog error
//
// Build option: SIC_MEM_ARB_WATCHDOG_EN adds a per-ownership cycle counter
// that force-ends ownership after TIMEOUT_CYCLES grant cycles and sets
// timeout_err. Without it, ownership is unbounded and timeout_err is 0.
// ---------------------------------------------------------------------------
module sic_mem_arbiter
    import sic_mem_arbiter_pkg::*;
#(
    parameter int NUM_SIC        = 4,
    parameter int ID_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_SIC-1:0]                   req,
    input  logic [NUM_SIC*ID_WIDTH-1:0]          req_issue_id,
    input  logic [NUM_SIC-1:0]                   release_lock,
    input  logic [ID_WIDTH-1:0]                  oldest_issue_id,
    input  logic [NUM_SIC*MEM_WORD_ADDR_W-1:0]   sic_addr,
    input  logic [NUM_SIC*32-1:0]                sic_wdata,
    input  logic [NUM_SIC-1:0]                   sic_wen,
    output logic [NUM_SIC-1:0]                   grant,
    output logic [MEM_WORD_ADDR_W-1:0]           mem_addr,
    output logic [31:0]                          mem_wdata,
    output logic                                 mem_wen,
    input  logic [31:0]                          mem_rdata,
    output logic [31:0]                          rdata,
    output logic                                 busy,
    output logic                                 timeout_err
);

    localparam int IDX_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

    if (NUM_SIC < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sic_mem_arbiter: NUM_SIC must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    mem_arb_state_t     state;
    logic [IDX_W-1:0]   own_idx;

    logic               own_rel;
    logic               own_abort;
    logic               own_timeout;
    logic               own_end;
    logic [NUM_SIC-1:0] excl;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;

    assign busy  = (state == ST_OWN);
    assign rdata = mem_rdata;

    // Ownership-ending events only ever look at the owner's own lines.
    always_comb begin
        own_rel   = busy & release_lock[own_idx];
        own_abort = busy & ~req[own_idx];
        own_end   = own_rel | own_abort | own_timeout;
        excl      = '0;
        if (busy) begin
            excl[own_idx] = 1'b1;
        end
    end

    sic_age_select #(
        .NUM_SIC  (NUM_SIC),
        .ID_WIDTH (ID_WIDTH),
        .IDX_W    (IDX_W)
    ) u_sel (
        .req       (req),
        .ids       (req_issue_id),
        .base      (oldest_issue_id),
        .excl      (excl),
        .win_idx   (sel_idx),
        .win_valid (sel_valid)
    );

`ifdef SIC_MEM_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             wd_err;

    // wd_cnt is the number of grant cycles already spent by the owner, so
    // the owner gets exactly TIMEOUT_CYCLES grant cycles.
    assign own_timeout = busy & ~own_rel & ~own_abort &
                         (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = wd_err;
`else
    assign own_timeout = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            own_idx <= '0;
`ifdef SIC_MEM_ARB_WATCHDOG_EN
            wd_cnt  <= '0;
            wd_err  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        own_idx <= sel_idx;
                        state   <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // Hand-off re-selects in the ending cycle (owner
                    // excluded) so the next grant follows with no gap.
                    if (own_end) begin
                        if (sel_valid) begin
                            own_idx <= sel_idx;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
`ifdef SIC_MEM_ARB_WATCHDOG_EN
            if (state == ST_IDLE || own_end) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (own_timeout) begin
                wd_err <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        grant     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        if (busy) begin
            grant[own_idx] = 1'b1;
            mem_addr  = sic_addr[int'(own_idx)*MEM_WORD_ADDR_W +: MEM_WORD_ADDR_W];
            mem_wdata = sic_wdata[int'(own_idx)*32 +: 32];
            mem_wen   = sic_wen[own_idx] & ~own_abort;
        end
    end

endmodule

// File: tb/tb_sic_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sic_mem_arbiter
// Scoreboard bench: the stimulus process drives one cycle of inputs, derives
// the expected outputs from a behavioural ownership model and queues them;
// a separate monitor pops and compares once the DUT outputs have settled.
// Each SIC is an agent that requests with an id, holds the grant for a set
// number of cycles, then releases (or aborts by dropping req).
// ---------------------------------------------------------------------------
module tb_sic_mem_arbiter;

    localparam int NUM_SIC        = 4;
    localparam int ID_WIDTH       = 6;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int ID_MOD         = 1 << ID_WIDTH;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_SIC-1:0]          req;
    logic [NUM_SIC*ID_WIDTH-1:0] req_issue_id;
    logic [NUM_SIC-1:0]          release_lock;
    logic [ID_WIDTH-1:0]         oldest_issue_id;
    logic [NUM_SIC*30-1:0]       sic_addr;
    logic [NUM_SIC*32-1:0]       sic_wdata;
    logic [NUM_SIC-1:0]          sic_wen;
    logic [NUM_SIC-1:0]          grant;
    logic [29:0]                 mem_addr;
    logic [31:0]                 mem_wdata;
    logic                        mem_wen;
    logic [31:0]                 mem_rdata;
    logic [31:0]                 rdata;
    logic                        busy;
    logic                        timeout_err;

    sic_mem_arbiter #(
        .NUM_SIC        (NUM_SIC),
        .ID_WIDTH       (ID_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .req_issue_id    (req_issue_id),
        .release_lock    (release_lock),
        .oldest_issue_id (oldest_issue_id),
        .sic_addr        (sic_addr),
        .sic_wdata       (sic_wdata),
        .sic_wen         (sic_wen),
        .grant           (grant),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wen         (mem_wen),
        .mem_rdata       (mem_rdata),
        .rdata           (rdata),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_SIC-1:0] grant;
        logic [29:0]        addr;
        logic [31:0]        wdata;
        logic               wen;
        logic               busy;
        logic               terr;
        logic [31:0]        rdata;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Agent state per SIC
    bit          active [NUM_SIC];
    logic [5:0]  aid    [NUM_SIC];
    int          hold   [NUM_SIC];
    bit          abrt   [NUM_SIC];
    logic [29:0] a_addr [NUM_SIC];
    logic [31:0] a_wdata[NUM_SIC];
    bit          a_wen  [NUM_SIC];
    int          cur_base = 0;
    bit          noise_en = 0;

    // Reference model: current owner (-1 none), grant cycles already used
    // by that owner, sticky watchdog flag.
    int m_owner  = -1;
    int m_cycles = 0;
    bit m_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_SIC-1:0] r, input int excl_i);
        int best = -1;
        int bage = 0;
        int age;
        for (int i = 0; i < NUM_SIC; i++) begin
            if (r[i] && i != excl_i) begin
                age = (int'(aid[i]) - cur_base + ID_MOD) % ID_MOD;
                if (best < 0 || age < bage) begin
                    best = i;
                    bage = age;
                end
            end
        end
        return best;
    endfunction

    task automatic drive_cycle(input bit rnd_data);
        logic [NUM_SIC-1:0] r;
        logic [NUM_SIC-1:0] rel;
        int   o;
        bit   released;
        bit   timed;
        bit   ended;
        exp_t e;
        @(negedge clk);
        if (rnd_data) begin
            for (int i = 0; i < NUM_SIC; i++) begin
                a_addr[i]  = 30'($urandom);
                a_wdata[i] = $urandom;
                a_wen[i]   = 1'($urandom);
            end
        end
        o        = m_owner;
        released = 0;
        for (int i = 0; i < NUM_SIC; i++) r[i] = active[i];
        rel = '0;
        if (noise_en) rel = NUM_SIC'($urandom);
        if (o >= 0) begin
            rel[o] = 1'b0;
            if (m_cycles >= hold[o]) begin
                if (abrt[o]) begin
                    r[o]      = 1'b0;
                    active[o] = 0;
                end else begin
                    rel[o]   = 1'b1;
                    released = 1;
                end
            end
        end
        req             = r;
        release_lock    = rel;
        oldest_issue_id = ID_WIDTH'(cur_base);
        mem_rdata       = $urandom;
        for (int i = 0; i < NUM_SIC; i++) begin
            req_issue_id[i*ID_WIDTH +: ID_WIDTH] = aid[i];
            sic_addr[i*30 +: 30]  = a_addr[i];
            sic_wdata[i*32 +: 32] = a_wdata[i];
            sic_wen[i]            = a_wen[i];
        end
        #1;
        e.grant = '0;
        e.addr  = '0;
        e.wdata = '0;
        e.wen   = 1'b0;
        e.busy  = (o >= 0);
        e.rdata = mem_rdata;
        if (o >= 0) begin
            e.grant[o] = 1'b1;
            e.addr     = a_addr[o];
            e.wdata    = a_wdata[o];
            e.wen      = a_wen[o] && r[o];
        end
        timed = 0;
`ifdef SIC_MEM_ARB_WATCHDOG_EN
        timed = (o >= 0) && (m_cycles == TIMEOUT_CYCLES - 1) && !rel[o] && r[o];
`endif
        e.terr = m_err;
        q.push_back(e);
        ended = (o >= 0) && (rel[o] || !r[o] || timed);
        if (timed) m_err = 1;
        if (o < 0 || ended) begin
            m_owner  = pick(r, o);
            m_cycles = 0;
        end else begin
            m_cycles++;
        end
        if (released) active[o] = 0;
    endtask

    task automatic start_req(input int i, input int id, input int h, input bit ab);
        active[i] = 1;
        aid[i]    = 6'(id);
        hold[i]   = h;
        abrt[i]   = ab;
    endtask

    task automatic clear_agents();
        for (int i = 0; i < NUM_SIC; i++) begin
            active[i]  = 0;
            aid[i]     = '0;
            hold[i]    = 0;
            abrt[i]    = 0;
            a_addr[i]  = '0;
            a_wdata[i] = '0;
            a_wen[i]   = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_mem_wen"}, 32'(mem_wen), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    // Monitor: samples settled outputs 1 time unit after stimulus is queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("grant", 32'(grant), 32'(e.grant));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("mem_wdata", mem_wdata, e.wdata);
                chk("mem_wen", 32'(mem_wen), 32'(e.wen));
                chk("rdata", rdata, e.rdata);
                chk("timeout_err", 32'(timeout_err), 32'(e.terr));
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        req             = '0;
        req_issue_id    = '0;
        release_lock    = '0;
        oldest_issue_id = '0;
        sic_addr        = '0;
        sic_wdata       = '0;
        sic_wen         = '0;
        mem_rdata       = '0;
        clear_agents();
        #12;
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // Single request: SIC2, id 5, base 0
        cur_base = 0;
        start_req(2, 5, 0, 0);
        repeat (4) drive_cycle(0);

        // Wrap-around age: base 62, SIC0 id 1, SIC1 id 63 -> SIC1 first
        cur_base = 62;
        start_req(0, 1, 0, 0);
        start_req(1, 63, 0, 0);
        repeat (5) drive_cycle(0);

        // Back-to-back hand-off 0,1,2,3
        cur_base = 0;
        for (int i = 0; i < NUM_SIC; i++) start_req(i, 10 + i, 0, 0);
        repeat (7) drive_cycle(0);

        // Write mux: SIC3 owner, others present write data but no request
        for (int i = 0; i < NUM_SIC; i++) begin
            a_addr[i]  = 30'(32'h200 + i);
            a_wdata[i] = 32'h1111_0000 + i;
            a_wen[i]   = 1;
        end
        a_addr[3]  = 30'h100;
        a_wdata[3] = 32'hDEAD_BEEF;
        start_req(3, 20, 0, 0);
        repeat (4) drive_cycle(0);

        // Abort: SIC1 owns with a pending write, drops req; SIC0 waiting
        start_req(1, 30, 1, 1);
        drive_cycle(0);
        start_req(0, 31, 0, 0);
        repeat (5) drive_cycle(0);

        // Long ownership: unbounded without watchdog, force-ended with it
        clear_agents();
        start_req(0, 40, 1000, 0);
        repeat (100) drive_cycle(0);
        active[0] = 0;
        repeat (3) drive_cycle(0);

        // Asynchronous reset in the middle of an owned write
        start_req(2, 7, 1000, 0);
        a_wen[2] = 1;
        repeat (3) drive_cycle(0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        m_owner  = -1;
        m_cycles = 0;
        m_err    = 0;
        clear_agents();
        #3 rst_n = 1'b1;

        // Randomised traffic with non-owner release noise
        noise_en = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) cur_base = int'($urandom_range(0, ID_MOD - 1));
            for (int i = 0; i < NUM_SIC; i++) begin
                if (!active[i] && m_owner != i && $urandom_range(0, 2) == 0) begin
                    start_req(i, (cur_base + int'($urandom_range(0, 7))) % ID_MOD,
                              int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
                end
            end
            drive_cycle(1);
        end
        noise_en = 0;
        clear_agents();
        repeat (6) drive_cycle(0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
